// File: rtl/axi_pkg.sv
// axi_pkg
// Shared encodings for the 2-master/2-slave AXI interconnect read path.
// The downstream R-data mux decodes current_Rstate and slave with these
// same enums, so the numeric values are part of the interface contract.
//   rstate_e   : R-channel sequencer state reported to the R mux
//   slave_e    : decoded target of the granted read
//   ar_state_e : internal AR arbiter FSM state
//   M0_TAG/M1_TAG : upper nibble of the forwarded ARID, stripped by the R mux
package axi_pkg;

  localparam int ID_W        = 4;
  localparam int BUS_ID_W    = 8;
  // Each slave region is 64 KiB, so only ADDR[31:16] takes part in decode.
  localparam int REGION_BITS = 16;

  localparam logic [3:0] M0_TAG = 4'h1;
  localparam logic [3:0] M1_TAG = 4'h2;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    M0_RDATA = 2'd1,
    M1_RDATA = 2'd2,
    R_ADDR   = 2'd3
  } rstate_e;

  typedef enum logic [1:0] {
    SLAVE0        = 2'd0,
    SLAVE1        = 2'd1,
    DEFAULT_SLAVE = 2'd2
  } slave_e;

  typedef enum logic [2:0] {
    IDLE,
    M0_ADDR,
    M1_ADDR,
    M0_DATA,
    M1_DATA
  } ar_state_e;

endpackage

// File: rtl/ar_read_arbiter_if.sv
// ar_read_arbiter_if
// AR-channel bundle between the two masters, the two slaves and the read
// arbiter, plus the R-beat handshake seen at the master side of the R mux.
//   M0/M1 side : ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID in, ARREADY out
//   S0/S1 side : ARID(8b tagged)/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID out, ARREADY in
//   R side     : RVALID/RREADY/RLAST per master (observed only)
// Modports:
//   slave  : the arbiter, which is the AR target of the masters
//   master : the surrounding environment (masters, slaves, R mux)
interface ar_read_arbiter_if;
  import axi_pkg::*;

  logic [ID_W-1:0]     ARID_M0,    ARID_M1;
  logic [31:0]         ARADDR_M0,  ARADDR_M1;
  logic [3:0]          ARLEN_M0,   ARLEN_M1;
  logic [2:0]          ARSIZE_M0,  ARSIZE_M1;
  logic [1:0]          ARBURST_M0, ARBURST_M1;
  logic                ARVALID_M0, ARVALID_M1;
  logic                ARREADY_M0, ARREADY_M1;

  logic [BUS_ID_W-1:0] ARID_S0,    ARID_S1;
  logic [31:0]         ARADDR_S0,  ARADDR_S1;
  logic [3:0]          ARLEN_S0,   ARLEN_S1;
  logic [2:0]          ARSIZE_S0,  ARSIZE_S1;
  logic [1:0]          ARBURST_S0, ARBURST_S1;
  logic                ARVALID_S0, ARVALID_S1;
  logic                ARREADY_S0, ARREADY_S1;

  logic                RVALID_M0,  RVALID_M1;
  logic                RREADY_M0,  RREADY_M1;
  logic                RLAST_M0,   RLAST_M1;

  modport slave (
    input  ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
           ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
           ARREADY_S0, ARREADY_S1,
           RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1, RLAST_M0, RLAST_M1,
    output ARREADY_M0, ARREADY_M1,
           ARID_S0, ARID_S1, ARADDR_S0, ARADDR_S1, ARLEN_S0, ARLEN_S1,
           ARSIZE_S0, ARSIZE_S1, ARBURST_S0, ARBURST_S1, ARVALID_S0, ARVALID_S1
  );

  modport master (
    output ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
           ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
           ARREADY_S0, ARREADY_S1,
           RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1, RLAST_M0, RLAST_M1,
    input  ARREADY_M0, ARREADY_M1,
           ARID_S0, ARID_S1, ARADDR_S0, ARADDR_S1, ARLEN_S0, ARLEN_S1,
           ARSIZE_S0, ARSIZE_S1, ARBURST_S0, ARBURST_S1, ARVALID_S0, ARVALID_S1
  );

endinterface

// File: rtl/ar_addr_decoder.sv
// ar_addr_decoder
// Combinational address-to-slave decode, shared by the AR and AW paths.
//   addr  in  32  request address
//   slave out 2   SLAVE0 / SLAVE1 / DEFAULT_SLAVE
// Parameters S0_BASE/S1_BASE give the 64 KiB region bases.
module ar_addr_decoder
  import axi_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000
) (
  input  logic [31:0] addr,
  output slave_e      slave
);

  // Anything outside both regions falls to the default slave.
  always_comb begin
    slave = DEFAULT_SLAVE;
    if (addr[31:REGION_BITS] == S0_BASE[31:REGION_BITS])
      slave = SLAVE0;
    else if (addr[31:REGION_BITS] == S1_BASE[31:REGION_BITS])
      slave = SLAVE1;
  end

endmodule

// File: rtl/ar_read_arbiter.sv
// ar_read_arbiter
// Read-address arbiter and read-transaction sequencer. Grants one AR request
// at a time, latches it, forwards it to the decoded slave (or acknowledges it
// locally for the default slave) and then tracks the R data phase until the
// RLAST beat. Only one read is outstanding at a time.
// Ports:
//   ACLK, ARESET    clock, asynchronous active-high reset
//   bus             ar_read_arbiter_if.slave (M0/M1 AR in, S0/S1 AR out, R beats)
//   current_Rstate  R_IDLE / R_ADDR / M0_RDATA / M1_RDATA for the R mux
//   slave           latched decode of the granted read
//   ARID_BUS        latched {tag, ARID}
//   ARLEN_BUS       latched ARLEN
//   ARBURST_BUS     latched ARBURST
// Configuration macro: AXI_RR_ARB_EN
//   defined   : round-robin on ties, pointer moves on every grant
//   undefined : fixed priority, M0 wins ties
module ar_read_arbiter
  import axi_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000
) (
  input  logic                ACLK,
  input  logic                ARESET,
  ar_read_arbiter_if.slave    bus,
  output rstate_e             current_Rstate,
  output slave_e              slave,
  output logic [BUS_ID_W-1:0] ARID_BUS,
  output logic [3:0]          ARLEN_BUS,
  output logic [1:0]          ARBURST_BUS
);

  ar_state_e           state, state_next;
  logic [BUS_ID_W-1:0] id_bus;
  logic [31:0]         addr_reg;
  logic [3:0]          len_bus;
  logic [2:0]          size_reg;
  logic [1:0]          burst_bus;
  slave_e              slave_reg;

  logic                grant_m1;
  logic                load;
  logic                addr_ack;
  logic [31:0]         sel_addr;
  slave_e              dec_slave;

`ifdef AXI_RR_ARB_EN
  logic                rr_m1_prio;

  // On a tie, the master that was not granted last wins.
  always_comb begin
    grant_m1 = bus.ARVALID_M1 && (!bus.ARVALID_M0 || rr_m1_prio);
  end

  // Pointer hands priority to the other master after every grant.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      rr_m1_prio <= 1'b0;
    else if (load)
      rr_m1_prio <= !grant_m1;
  end
`else
  // Fixed priority: M1 only wins when M0 is not requesting.
  always_comb begin
    grant_m1 = bus.ARVALID_M1 && !bus.ARVALID_M0;
  end
`endif

  assign load     = (state == IDLE) && (bus.ARVALID_M0 || bus.ARVALID_M1);
  assign sel_addr = grant_m1 ? bus.ARADDR_M1 : bus.ARADDR_M0;

  ar_addr_decoder #(
    .S0_BASE (S0_BASE),
    .S1_BASE (S1_BASE)
  ) u_decoder (
    .addr  (sel_addr),
    .slave (dec_slave)
  );

  // State register and bus registers; the request is captured in the grant
  // cycle and held unchanged through the address and data phases.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      id_bus    <= '0;
      addr_reg  <= '0;
      len_bus   <= '0;
      size_reg  <= '0;
      burst_bus <= '0;
      slave_reg <= DEFAULT_SLAVE;
    end else begin
      state <= state_next;
      if (load) begin
        id_bus    <= grant_m1 ? {M1_TAG, bus.ARID_M1} : {M0_TAG, bus.ARID_M0};
        addr_reg  <= sel_addr;
        len_bus   <= grant_m1 ? bus.ARLEN_M1   : bus.ARLEN_M0;
        size_reg  <= grant_m1 ? bus.ARSIZE_M1  : bus.ARSIZE_M0;
        burst_bus <= grant_m1 ? bus.ARBURST_M1 : bus.ARBURST_M0;
        slave_reg <= dec_slave;
      end
    end
  end

  // Next state and all channel outputs. In the address phase a real slave
  // sees ARVALID from the registers and its ARREADY is passed straight back
  // to the granted master; the default slave is acknowledged locally.
  always_comb begin
    state_next     = state;
    addr_ack       = 1'b0;
    current_Rstate = R_IDLE;
    bus.ARREADY_M0 = 1'b0;
    bus.ARREADY_M1 = 1'b0;
    bus.ARVALID_S0 = 1'b0;
    bus.ARID_S0    = '0;
    bus.ARADDR_S0  = '0;
    bus.ARLEN_S0   = '0;
    bus.ARSIZE_S0  = '0;
    bus.ARBURST_S0 = '0;
    bus.ARVALID_S1 = 1'b0;
    bus.ARID_S1    = '0;
    bus.ARADDR_S1  = '0;
    bus.ARLEN_S1   = '0;
    bus.ARSIZE_S1  = '0;
    bus.ARBURST_S1 = '0;

    case (state)
      IDLE: begin
        if (load)
          state_next = grant_m1 ? M1_ADDR : M0_ADDR;
      end
      M0_ADDR, M1_ADDR: begin
        current_Rstate = R_ADDR;
        case (slave_reg)
          SLAVE0: begin
            bus.ARVALID_S0 = 1'b1;
            bus.ARID_S0    = id_bus;
            bus.ARADDR_S0  = addr_reg;
            bus.ARLEN_S0   = len_bus;
            bus.ARSIZE_S0  = size_reg;
            bus.ARBURST_S0 = burst_bus;
            addr_ack       = bus.ARREADY_S0;
          end
          SLAVE1: begin
            bus.ARVALID_S1 = 1'b1;
            bus.ARID_S1    = id_bus;
            bus.ARADDR_S1  = addr_reg;
            bus.ARLEN_S1   = len_bus;
            bus.ARSIZE_S1  = size_reg;
            bus.ARBURST_S1 = burst_bus;
            addr_ack       = bus.ARREADY_S1;
          end
          default: addr_ack = 1'b1;
        endcase
        if (state == M0_ADDR)
          bus.ARREADY_M0 = addr_ack;
        else
          bus.ARREADY_M1 = addr_ack;
        if (addr_ack)
          state_next = (state == M0_ADDR) ? M0_DATA : M1_DATA;
      end
      M0_DATA: begin
        current_Rstate = M0_RDATA;
        if (bus.RVALID_M0 && bus.RREADY_M0 && bus.RLAST_M0)
          state_next = IDLE;
      end
      M1_DATA: begin
        current_Rstate = M1_RDATA;
        if (bus.RVALID_M1 && bus.RREADY_M1 && bus.RLAST_M1)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign slave       = slave_reg;
  assign ARID_BUS    = id_bus;
  assign ARLEN_BUS   = len_bus;
  assign ARBURST_BUS = burst_bus;

endmodule

// File: tb/tb_ar_read_arbiter.sv
// tb_ar_read_arbiter
// Scoreboard bench for ar_read_arbiter: every request pushes its expected
// forwarded transaction, and each AR acknowledge pops and compares it.
// Inputs are driven on the falling edge, outputs sampled there (+1 for the
// combinational ARREADY pass-through). Honours AXI_RR_ARB_EN for the tie test.
module tb_ar_read_arbiter;
  import axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET;
  rstate_e     current_Rstate;
  slave_e      slave_sel;
  logic [7:0]  ARID_BUS;
  logic [3:0]  ARLEN_BUS;
  logic [1:0]  ARBURST_BUS;

  ar_read_arbiter_if bus();

  ar_read_arbiter dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .bus            (bus),
    .current_Rstate (current_Rstate),
    .slave          (slave_sel),
    .ARID_BUS       (ARID_BUS),
    .ARLEN_BUS      (ARLEN_BUS),
    .ARBURST_BUS    (ARBURST_BUS)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int         master;
    logic [1:0] slv;
    logic [7:0] id_s;
    logic [31:0] addr;
    logic [3:0] len;
    logic [1:0] burst;
  } exp_t;

  exp_t sb[$];
  int   check_count = 0;
  int   fail_count  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Region model written as range checks rather than field compares.
  function automatic logic [1:0] modelSlave(input logic [31:0] a);
    if (a < 32'h0001_0000) return 2'd0;
    if (a < 32'h0002_0000) return 2'd1;
    return 2'd2;
  endfunction

  task automatic pushExpected(input int m, input logic [31:0] addr, input logic [3:0] id,
                              input logic [3:0] len, input logic [1:0] burst);
    exp_t e;
    e.master = m;
    e.slv    = modelSlave(addr);
    e.id_s   = {(m == 0) ? 4'h1 : 4'h2, id};
    e.addr   = addr;
    e.len    = len;
    e.burst  = burst;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int m, input logic [31:0] addr, input logic [3:0] id,
                               input logic [3:0] len, input logic [1:0] burst);
    if (m == 0) begin
      bus.ARID_M0 = id; bus.ARADDR_M0 = addr; bus.ARLEN_M0 = len;
      bus.ARSIZE_M0 = 3'd2; bus.ARBURST_M0 = burst; bus.ARVALID_M0 = 1'b1;
    end else begin
      bus.ARID_M1 = id; bus.ARADDR_M1 = addr; bus.ARLEN_M1 = len;
      bus.ARSIZE_M1 = 3'd2; bus.ARBURST_M1 = burst; bus.ARVALID_M1 = 1'b1;
    end
  endtask

  task automatic driveR(input int m, input logic v, input logic r, input logic l);
    if (m == 0) begin
      bus.RVALID_M0 = v; bus.RREADY_M0 = r; bus.RLAST_M0 = l;
    end else begin
      bus.RVALID_M1 = v; bus.RREADY_M1 = r; bus.RLAST_M1 = l;
    end
  endtask

  // Waits for an AR acknowledge, acting as the slave with ARREADY raised in
  // the ready_wait-th cycle of ARVALID_S*, then checks against the scoreboard.
  task automatic addrPhase(input int ready_wait, input bit keep_valid, output int granted);
    int   cnt;
    exp_t e;
    cnt     = 0;
    granted = -1;
    for (int c = 0; c < 20 && granted < 0; c++) begin
      @(negedge ACLK);
      if (bus.ARVALID_S0 || bus.ARVALID_S1) begin
        cnt++;
        if (cnt >= ready_wait) begin
          bus.ARREADY_S0 = bus.ARVALID_S0;
          bus.ARREADY_S1 = bus.ARVALID_S1;
        end
      end
      #1;
      if (bus.ARREADY_M0)      granted = 0;
      else if (bus.ARREADY_M1) granted = 1;
    end
    if (granted < 0) begin
      checkOutput("ar_ack_timeout", 32'd0, 32'd1);
      granted = 0;
      return;
    end
    if (sb.size() == 0) begin
      checkOutput("sb_unexpected_grant", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkOutput("grant_master", 32'(granted), 32'(e.master));
    checkOutput("loser_ready", 32'((granted == 0) ? bus.ARREADY_M1 : bus.ARREADY_M0), 32'd0);
    checkOutput("rstate_addr", 32'(current_Rstate), 32'd3);
    checkOutput("slave", 32'(slave_sel), 32'(e.slv));
    checkOutput("arid_bus", 32'(ARID_BUS), 32'(e.id_s));
    checkOutput("arlen_bus", 32'(ARLEN_BUS), 32'(e.len));
    checkOutput("arburst_bus", 32'(ARBURST_BUS), 32'(e.burst));
    if (e.slv == 2'd0) begin
      checkOutput("arvalid_s0", 32'(bus.ARVALID_S0), 32'd1);
      checkOutput("arid_s0", 32'(bus.ARID_S0), 32'(e.id_s));
      checkOutput("araddr_s0", bus.ARADDR_S0, e.addr);
      checkOutput("arlen_s0", 32'(bus.ARLEN_S0), 32'(e.len));
      checkOutput("arvalid_s1_off", 32'(bus.ARVALID_S1), 32'd0);
      checkOutput("araddr_s1_off", bus.ARADDR_S1, 32'd0);
      checkOutput("arvalid_hold", 32'(cnt), 32'(ready_wait));
    end else if (e.slv == 2'd1) begin
      checkOutput("arvalid_s1", 32'(bus.ARVALID_S1), 32'd1);
      checkOutput("arid_s1", 32'(bus.ARID_S1), 32'(e.id_s));
      checkOutput("araddr_s1", bus.ARADDR_S1, e.addr);
      checkOutput("arlen_s1", 32'(bus.ARLEN_S1), 32'(e.len));
      checkOutput("arvalid_s0_off", 32'(bus.ARVALID_S0), 32'd0);
      checkOutput("araddr_s0_off", bus.ARADDR_S0, 32'd0);
      checkOutput("arvalid_hold", 32'(cnt), 32'(ready_wait));
    end else begin
      checkOutput("dflt_arvalid_s0", 32'(bus.ARVALID_S0), 32'd0);
      checkOutput("dflt_arvalid_s1", 32'(bus.ARVALID_S1), 32'd0);
      checkOutput("dflt_no_slave_cycles", 32'(cnt), 32'd0);
    end
    @(negedge ACLK);
    bus.ARREADY_S0 = 1'b0;
    bus.ARREADY_S1 = 1'b0;
    if (!keep_valid) begin
      if (granted == 0) bus.ARVALID_M0 = 1'b0;
      else              bus.ARVALID_M1 = 1'b0;
    end
    checkOutput("arready_single_pulse",
                32'((granted == 0) ? bus.ARREADY_M0 : bus.ARREADY_M1), 32'd0);
  endtask

  // Delivers the R beats; optional stall offers RLAST without RREADY first.
  task automatic dataPhase(input int m, input int beats, input bit stall);
    logic [1:0] exp_r;
    exp_r = (m == 0) ? 2'd1 : 2'd2;
    for (int b = 0; b < beats; b++) begin
      checkOutput("rstate_data", 32'(current_Rstate), 32'(exp_r));
      if (stall && b == beats - 1) begin
        driveR(m, 1'b1, 1'b0, 1'b1);
        @(negedge ACLK);
        checkOutput("rstate_stall", 32'(current_Rstate), 32'(exp_r));
      end
      driveR(m, 1'b1, 1'b1, (b == beats - 1));
      @(negedge ACLK);
    end
    driveR(m, 1'b0, 1'b0, 1'b0);
    checkOutput("rstate_idle_after_last", 32'(current_Rstate), 32'd0);
  endtask

  initial begin
    int g;
    int order [4];
    ARESET = 1'b1;
    bus.ARID_M0 = '0; bus.ARADDR_M0 = '0; bus.ARLEN_M0 = '0; bus.ARSIZE_M0 = '0;
    bus.ARBURST_M0 = '0; bus.ARVALID_M0 = 1'b0;
    bus.ARID_M1 = '0; bus.ARADDR_M1 = '0; bus.ARLEN_M1 = '0; bus.ARSIZE_M1 = '0;
    bus.ARBURST_M1 = '0; bus.ARVALID_M1 = 1'b0;
    bus.ARREADY_S0 = 1'b0; bus.ARREADY_S1 = 1'b0;
    driveR(0, 1'b0, 1'b0, 1'b0);
    driveR(1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge ACLK);
    checkOutput("reset_rstate", 32'(current_Rstate), 32'd0);
    checkOutput("reset_slave", 32'(slave_sel), 32'd2);
    checkOutput("reset_arid_bus", 32'(ARID_BUS), 32'd0);
    checkOutput("reset_arvalid_s", 32'({bus.ARVALID_S0, bus.ARVALID_S1}), 32'd0);
    checkOutput("reset_arready_m", 32'({bus.ARREADY_M0, bus.ARREADY_M1}), 32'd0);
    ARESET = 1'b0;

    // Both masters request continuously for four reads.
    $display("[TB] tie arbitration");
`ifdef AXI_RR_ARB_EN
    order = '{0, 1, 0, 1};
`else
    order = '{0, 0, 0, 0};
`endif
    applyStimulus(0, 32'h0000_0200, 4'h3, 4'd0, 2'b01);
    applyStimulus(1, 32'h0001_0300, 4'h5, 4'd1, 2'b01);
    for (int k = 0; k < 4; k++) begin
      if (order[k] == 0) pushExpected(0, 32'h0000_0200, 4'h3, 4'd0, 2'b01);
      else               pushExpected(1, 32'h0001_0300, 4'h5, 4'd1, 2'b01);
    end
    for (int k = 0; k < 4; k++) begin
      addrPhase(1, 1'b1, g);
      dataPhase(g, (g == 0) ? 1 : 2, 1'b0);
    end
    bus.ARVALID_M0 = 1'b0;
    bus.ARVALID_M1 = 1'b0;

    $display("[TB] M0 single read to S0, slow ARREADY");
    applyStimulus(0, 32'h0000_0010, 4'h4, 4'd0, 2'b01);
    pushExpected(0, 32'h0000_0010, 4'h4, 4'd0, 2'b01);
    addrPhase(2, 1'b0, g);
    dataPhase(0, 1, 1'b0);

    $display("[TB] M1 INCR burst of 4 to S1");
    applyStimulus(1, 32'h0001_0040, 4'h7, 4'd3, 2'b01);
    pushExpected(1, 32'h0001_0040, 4'h7, 4'd3, 2'b01);
    addrPhase(1, 1'b0, g);
    dataPhase(1, 4, 1'b1);

    $display("[TB] M0 read to default slave");
    applyStimulus(0, 32'h0002_0000, 4'h9, 4'd1, 2'b10);
    pushExpected(0, 32'h0002_0000, 4'h9, 4'd1, 2'b10);
    addrPhase(1, 1'b0, g);
    dataPhase(0, 2, 1'b0);

    $display("[TB] reset during M1 burst");
    applyStimulus(1, 32'h0001_0080, 4'hA, 4'd3, 2'b01);
    pushExpected(1, 32'h0001_0080, 4'hA, 4'd3, 2'b01);
    addrPhase(1, 1'b0, g);
    for (int b = 0; b < 2; b++) begin
      driveR(1, 1'b1, 1'b1, 1'b0);
      @(negedge ACLK);
    end
    checkOutput("mid_burst_rstate", 32'(current_Rstate), 32'd2);
    driveR(1, 1'b0, 1'b0, 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    checkOutput("post_reset_rstate", 32'(current_Rstate), 32'd0);
    checkOutput("post_reset_arvalid_s", 32'({bus.ARVALID_S0, bus.ARVALID_S1}), 32'd0);
    checkOutput("post_reset_arready_m", 32'({bus.ARREADY_M0, bus.ARREADY_M1}), 32'd0);
    checkOutput("post_reset_arid_bus", 32'(ARID_BUS), 32'd0);
    checkOutput("post_reset_arlen_bus", 32'(ARLEN_BUS), 32'd0);
    checkOutput("post_reset_slave", 32'(slave_sel), 32'd2);
    @(negedge ACLK);
    checkOutput("post_reset_stays_idle", 32'(current_Rstate), 32'd0);

    applyStimulus(0, 32'h0000_0100, 4'h2, 4'd1, 2'b01);
    pushExpected(0, 32'h0000_0100, 4'h2, 4'd1, 2'b01);
    addrPhase(1, 1'b0, g);
    dataPhase(0, 2, 1'b0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
